// File: rtl/count_delta_sampler.sv
// -----------------------------------------------------------------------------
// count_delta_sampler
//
// Periodically samples a free-running event counter and reports the
// increment since the previous sample. The increment is computed modulo
// 2^CNT_W, so a counter wrap between two samples is harmless. Each delta is
// tagged with a sequence number and queued in a small FIFO. The FIFO is
// drained through a valid/ready master port.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   count_i    counter value (CNT_W bits, synchronous to clk)
//   sample_en  enables sampling; low parks the sampler in IDLE
//   m_valid    FIFO head entry available
//   m_ready    consumer accepts the head entry
//   m_data     delta of the head entry
//   m_seq      sequence number of the head entry
//   level      number of FIFO entries (0..DEPTH)
//   overflow   sticky flag: a sample was dropped because the FIFO was full
//   clr_ovf    synchronous clear of overflow
// -----------------------------------------------------------------------------
module count_delta_sampler #(
   parameter int CNT_W  = 8,
   parameter int PERIOD = 16,   // 2..65535
   parameter int DEPTH  = 4,    // power of 2, >= 2
   parameter int SEQ_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CNT_W-1:0]           count_i,
   input  logic                       sample_en,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [CNT_W-1:0]           m_data,
   output logic [SEQ_W-1:0]           m_seq,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;
   localparam int TMR_W = $clog2(PERIOD);

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(PERIOD - 1);
   localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Sampler state
   // -------------------------------------------------------------------------
   state_t              state_reg,    state_next;
   logic [TMR_W-1:0]    timer_reg,    timer_next;
   logic [CNT_W-1:0]    baseline_reg, baseline_next;
   logic [SEQ_W-1:0]    seq_reg,      seq_next;
   logic                sample_event;
   logic [CNT_W-1:0]    delta;

   // Unsigned CNT_W-bit subtraction wraps naturally, which absorbs a counter
   // roll-over between two samples.
   assign delta = count_i - baseline_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         timer_reg    <= '0;
         baseline_reg <= '0;
         seq_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         baseline_reg <= baseline_next;
         seq_reg      <= seq_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg;
      baseline_next = baseline_reg;
      seq_next      = seq_reg;
      sample_event  = 1'b0;

      case (state_reg)
         IDLE: begin
            timer_next = '0;
            if (sample_en) begin
               state_next = PRIME;
            end
         end

         // A fresh baseline is always taken on (re-)enable so that counts
         // accumulated while disabled are never reported as a delta.
         PRIME: begin
            if (!sample_en) begin
               state_next = IDLE;
            end else begin
               baseline_next = count_i;
               timer_next    = '0;
               state_next    = RUN;
            end
         end

         RUN: begin
            if (!sample_en) begin
               // Disabling wins over a coincident sample event.
               state_next = IDLE;
               timer_next = '0;
            end else if (timer_reg == TMR_LAST) begin
               sample_event  = 1'b1;
               baseline_next = count_i;
               timer_next    = '0;
               // Sequence advances even when the FIFO drops the entry, so
               // the consumer can detect the gap.
               seq_next      = seq_reg + 1'b1;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FIFO
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] mem_data_reg [DEPTH];
   logic [SEQ_W-1:0] mem_seq_reg  [DEPTH];
   logic [AW-1:0]    wr_ptr_reg,   wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg,   rd_ptr_next;
   logic [LW-1:0]    level_reg,    level_next;
   logic             overflow_reg, overflow_next;
   logic             fifo_full;
   logic             pop;
   logic             push_ok;
   logic             drop;

   assign fifo_full = (level_reg == LVL_FULL);
   assign pop       = m_valid && m_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_ok   = sample_event && (!fifo_full || pop);
   assign drop      = sample_event && fifo_full && !pop;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_data_reg[gi] <= '0;
               mem_seq_reg[gi]  <= '0;
            end else if (push_ok && (wr_ptr_reg == AW'(gi))) begin
               mem_data_reg[gi] <= delta;
               mem_seq_reg[gi]  <= seq_reg;
            end
         end
      end
   endgenerate

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      level_next    = level_reg;
      overflow_next = overflow_reg;

      // DEPTH is a power of 2, so the pointers wrap on their own.
      if (push_ok) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end

      case ({push_ok, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase

      // A new drop takes precedence over a clear in the same cycle.
      if (drop) begin
         overflow_next = 1'b1;
      end else if (clr_ovf) begin
         overflow_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         level_reg    <= level_next;
         overflow_reg <= overflow_next;
      end
   end

   // Outputs come straight from registers, so the head stays stable while
   // the consumer stalls.
   assign m_valid  = (level_reg != '0);
   assign m_data   = mem_data_reg[rd_ptr_reg];
   assign m_seq    = mem_seq_reg[rd_ptr_reg];
   assign level    = level_reg;
   assign overflow = overflow_reg;

endmodule
